time_set_editor: RTL and testbench
==================================

Name: time_set_editor

Overview:
- Upstream stage of the running-clock counter: drives its SET strobe and the eight BCD preset digits (S*).
- Lets the user edit the time and date with three DE2 pushbuttons: MODE, UP and DOWN.
- On entry it captures the live clock digits, steps through DAY→HOUR→MIN→SEC fields, and commits with a one-cycle SET pulse.
- CANCEL or a timeout abandons the edit without SET.

Parameters:
- DB_CYCLES, 4: consecutive stable samples required to accept a button level change.
- TIMEOUT, 30000: idle cycles in an edit state before auto-cancel; 0 disables.
- BLINK_HALF, 2500: cycles per BLINK half-period.

Ports:
- CLK  in  1  system clock
- RSTN  in  1  asynchronous active-low reset
- KEY_MODE_N  in  1  raw MODE button, active-low, asynchronous
- KEY_UP_N  in  1  raw UP button, active-low
- KEY_DOWN_N  in  1  raw DOWN button, active-low
- KEY_CANCEL_N  in  1  raw CANCEL button, active-low
- SEC0,SEC1,MIN0,MIN1,HOUR0,HOUR1,DAY0,DAY1  in  4 each  live BCD time from the clock counter
- SSEC0,SSEC1,SMIN0,SMIN1,SHOUR0,SHOUR1,SDAY0,SDAY1  out  4 each  edited BCD preset
- SET  out  1  one-cycle commit strobe
- EDITING  out  1  high in any edit state
- FIELD  out  2  field being edited: 0=DAY, 1=HOUR, 2=MIN, 3=SEC
- BLINK  out  1  display-blank phase for the active field

Behaviour:
- Reset values: S* = 0 except SDAY0=1; SET=0; EDITING=0; FIELD=0; BLINK=0; state IDLE; debouncers hold "released"; timers 0.
- Button input path:
  - Each key passes through a 2-flop synchronizer, then a debouncer.
  - The debouncer changes level only after DB_CYCLES consecutive identical synchronized samples.
  - Debounced press-edge (released→pressed) makes a 1-cycle pulse PM/PU/PD/PC.
  - Latency from raw edge to pulse: 2 + DB_CYCLES cycles.
- Press priority, same cycle: PC > PM > (PU xor PD).
  - PU and PD together are ignored.
  - Only the highest-priority pulse acts.
- States: IDLE, LOAD, E_DAY, E_HOUR, E_MIN, E_SEC, COMMIT.
  - IDLE: PM→LOAD. All other pulses are ignored.
  - LOAD, one cycle: copy live digits into S* with sanitising, then go to E_DAY.
    - Day outside 01..31 → 01.
    - Hour outside 00..23 → 00.
    - Min/sec outside 00..59 → 00.
    - Any digit >9 makes its whole pair invalid.
  - E_x: PU increments the field pair, PD decrements it, PM advances to the next field. PM in E_SEC→COMMIT.
  - Any E_x: PC→IDLE. S* keep their edited values; SET is not asserted.
  - COMMIT, one cycle: SET=1, then IDLE. S* remain stable through the SET cycle and afterwards.
- FIELD = 0/1/2/3 in E_DAY/E_HOUR/E_MIN/E_SEC; 0 otherwise. EDITING=1 in LOAD, E_*, COMMIT.
- Field arithmetic: on the BCD pair, treated as a decimal value, with wrap.
  - DAY: 01..31; 31+1→01, 01−1→31.
  - HOUR: 00..23; 23+1→00, 00−1→23.
  - MIN/SEC: 00..59; 59+1→00, 00−1→59.
  - Units digit 9+1→0 with tens+1; units 0−1→9 with tens−1.
  - No edit ever produces an out-of-range pair.
- Timeout:
  - Counter clears on entry to E_DAY and on any accepted pulse; increments every cycle in E_*.
  - When TIMEOUT≠0 and the count reaches TIMEOUT, go to IDLE with no SET (same as cancel).
- BLINK:
  - Toggles every BLINK_HALF cycles while in E_*.
  - Forced to 0, with its counter cleared, outside E_*.
  - Its counter restarts on any field change, so the newly entered field shows first.
- Reset mid-edit: immediate return to reset values. No SET is issued.
- Held buttons produce a single pulse; there is no auto-repeat.

Test Plan:
- Reset → S*=00:00:00 day 01, SET=0, EDITING=0, FIELD=0.
- Live 15 day, 09:59:58; MODE press → after 2+DB_CYCLES+1 cycles FIELD=0, S* = 15/09:59:58.
  - Then MODE, UP → SHOUR=10.
  - Then MODE×3 → exactly one SET cycle, S* = 15/10:59:58, EDITING falls the cycle after.
- Wraps:
  - DAY 31 UP→01, DAY 01 DOWN→31.
  - HOUR 23 UP→00, HOUR 00 DOWN→23.
  - MIN 59 UP→00, SEC 00 DOWN→59, SEC 09 UP→10.
- Live day=35, hour=27, SEC1=0xA → LOAD yields day 01, hour 00, sec 00; min unchanged.
- Priority and single-shot:
  - UP+DOWN released together → no change.
  - MODE+UP together → field advances, value unchanged.
  - Glitch shorter than DB_CYCLES → no pulse.
  - Held UP for 1000 cycles → +1 only.
- Cancel and timeout:
  - CANCEL in E_MIN → IDLE, SET never asserted.
  - TIMEOUT=100 with no presses → IDLE exactly 100 cycles after the last accepted pulse, no SET.
  - RSTN low mid-E_HOUR → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/time_set_editor.sv
// Time/date preset editor: debounced MODE/UP/DOWN/CANCEL keys walk DAY->HOUR->MIN->SEC,
// edit BCD pairs with wrap, and commit the preset to the clock counter with a one-cycle SET.
module tse_key_db #(
  parameter int DB_CYCLES = 4
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic key_n_i,
  output logic press_o
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]    sync_q;
  logic          prs_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sync_q  <= 2'b11;
      prs_q   <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      press_q <= 1'b0;
      if (~sync_q[1] == prs_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
        prs_q   <= ~sync_q[1];
        press_q <= ~sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press_o = press_q;
endmodule

module time_set_editor #(
  parameter int DB_CYCLES  = 4,
  parameter int TIMEOUT    = 30000,
  parameter int BLINK_HALF = 2500
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       KEY_MODE_N,
  input  logic       KEY_UP_N,
  input  logic       KEY_DOWN_N,
  input  logic       KEY_CANCEL_N,
  input  logic [3:0] SEC0,
  input  logic [3:0] SEC1,
  input  logic [3:0] MIN0,
  input  logic [3:0] MIN1,
  input  logic [3:0] HOUR0,
  input  logic [3:0] HOUR1,
  input  logic [3:0] DAY0,
  input  logic [3:0] DAY1,
  output logic [3:0] SSEC0,
  output logic [3:0] SSEC1,
  output logic [3:0] SMIN0,
  output logic [3:0] SMIN1,
  output logic [3:0] SHOUR0,
  output logic [3:0] SHOUR1,
  output logic [3:0] SDAY0,
  output logic [3:0] SDAY1,
  output logic       SET,
  output logic       EDITING,
  output logic [1:0] FIELD,
  output logic       BLINK
);
  localparam int NK   = 4;
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int BL_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, E_DAY, E_HOUR, E_MIN, E_SEC, COMMIT} state_t;

  logic [NK-1:0] key_n, pulse;
  logic          pm, pu, pd, pc, step, to_hit;
  state_t        state_q, state_d;
  logic [7:0]    day_q, hr_q, mn_q, sc_q;
  logic [TO_W-1:0] to_q;
  logic [BL_W-1:0] bl_cnt_q;
  logic          blink_q, set_q, editing_q;
  logic [1:0]    field_q;

  assign key_n = {KEY_CANCEL_N, KEY_DOWN_N, KEY_UP_N, KEY_MODE_N};

  for (genvar k = 0; k < NK; k++) begin : g_key
    tse_key_db #(.DB_CYCLES(DB_CYCLES)) u_db (
      .CLK(CLK), .RSTN(RSTN), .key_n_i(key_n[k]), .press_o(pulse[k])
    );
  end

  assign pm     = pulse[0];
  assign pu     = pulse[1];
  assign pd     = pulse[2];
  assign pc     = pulse[3];
  assign step   = pu ^ pd;
  assign to_hit = (TIMEOUT != 0) && (to_q == TO_W'(TIMEOUT - 1));

  function automatic logic is_edit(input state_t st);
    return (st == E_DAY) || (st == E_HOUR) || (st == E_MIN) || (st == E_SEC);
  endfunction

  function automatic logic [1:0] field_of(input state_t st);
    case (st)
      E_HOUR:  return 2'd1;
      E_MIN:   return 2'd2;
      E_SEC:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // A bad digit anywhere in the pair, or an out-of-range value, falls back to the field minimum.
  function automatic logic [7:0] bcd_san(input logic [3:0] t, input logic [3:0] u,
                                         input logic [6:0] lo, input logic [6:0] hi);
    logic [6:0] v;
    if (t > 4'd9 || u > 4'd9) return {4'd0, lo[3:0]};
    v = 7'(t) * 7'd10 + 7'(u);
    if (v < lo || v > hi) return {4'd0, lo[3:0]};
    return {t, u};
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] p, input logic [7:0] lo,
                                         input logic [7:0] hi);
    if (p == hi) return lo;
    if (p[3:0] == 4'd9) return {p[7:4] + 4'd1, 4'd0};
    return {p[7:4], p[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] p, input logic [7:0] lo,
                                         input logic [7:0] hi);
    if (p == lo) return hi;
    if (p[3:0] == 4'd0) return {p[7:4] - 4'd1, 4'd9};
    return {p[7:4], p[3:0] - 4'd1};
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pm && !pc) state_d = LOAD;
      LOAD:    state_d = E_DAY;
      E_DAY:   if (pc) state_d = IDLE; else if (pm) state_d = E_HOUR;
               else if (!step && to_hit) state_d = IDLE;
      E_HOUR:  if (pc) state_d = IDLE; else if (pm) state_d = E_MIN;
               else if (!step && to_hit) state_d = IDLE;
      E_MIN:   if (pc) state_d = IDLE; else if (pm) state_d = E_SEC;
               else if (!step && to_hit) state_d = IDLE;
      E_SEC:   if (pc) state_d = IDLE; else if (pm) state_d = COMMIT;
               else if (!step && to_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      day_q     <= 8'h01;
      hr_q      <= 8'h00;
      mn_q      <= 8'h00;
      sc_q      <= 8'h00;
      to_q      <= '0;
      bl_cnt_q  <= '0;
      blink_q   <= 1'b0;
      set_q     <= 1'b0;
      editing_q <= 1'b0;
      field_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      set_q     <= (state_d == COMMIT);
      editing_q <= (state_d != IDLE);
      field_q   <= field_of(state_d);

      if (state_q == LOAD) begin
        day_q <= bcd_san(DAY1, DAY0, 7'd1, 7'd31);
        hr_q  <= bcd_san(HOUR1, HOUR0, 7'd0, 7'd23);
        mn_q  <= bcd_san(MIN1, MIN0, 7'd0, 7'd59);
        sc_q  <= bcd_san(SEC1, SEC0, 7'd0, 7'd59);
      end else if (is_edit(state_q) && !pc && !pm && step) begin
        case (state_q)
          E_DAY:   day_q <= pu ? bcd_inc(day_q, 8'h01, 8'h31) : bcd_dec(day_q, 8'h01, 8'h31);
          E_HOUR:  hr_q  <= pu ? bcd_inc(hr_q, 8'h00, 8'h23)  : bcd_dec(hr_q, 8'h00, 8'h23);
          E_MIN:   mn_q  <= pu ? bcd_inc(mn_q, 8'h00, 8'h59)  : bcd_dec(mn_q, 8'h00, 8'h59);
          default: sc_q  <= pu ? bcd_inc(sc_q, 8'h00, 8'h59)  : bcd_dec(sc_q, 8'h00, 8'h59);
        endcase
      end

      if (state_q == LOAD || (is_edit(state_q) && (pc || pm || step))) to_q <= '0;
      else if (is_edit(state_q))                                         to_q <= to_q + TO_W'(1);
      else                                                               to_q <= '0;

      // Restart the blink phase on every field change so the new field is shown first.
      if (!is_edit(state_d) || state_d != state_q) begin
        bl_cnt_q <= '0;
        blink_q  <= 1'b0;
      end else if (bl_cnt_q == BL_W'(BLINK_HALF - 1)) begin
        bl_cnt_q <= '0;
        blink_q  <= ~blink_q;
      end else begin
        bl_cnt_q <= bl_cnt_q + BL_W'(1);
      end
    end
  end

  assign {SDAY1, SDAY0}   = day_q;
  assign {SHOUR1, SHOUR0} = hr_q;
  assign {SMIN1, SMIN0}   = mn_q;
  assign {SSEC1, SSEC0}   = sc_q;
  assign SET     = set_q;
  assign EDITING = editing_q;
  assign FIELD   = field_q;
  assign BLINK   = blink_q;
endmodule

// File: tb/tb_time_set_editor.sv
// Directed bench for time_set_editor: vector table for field wraps/sanitising plus
// hand sequences for latency, commit, priority, debounce, cancel, timeout, blink, reset.
module tb_time_set_editor;
  localparam logic [3:0] K_MODE = 4'b0001, K_UP = 4'b0010, K_DN = 4'b0100, K_CAN = 4'b1000;

  logic             CLK = 1'b0, RSTN = 1'b0;
  logic [3:0]       keys_n = 4'hF;
  logic [7:0][3:0]  live = '0;
  wire  [7:0][3:0]  sa, sb;
  wire              seta, eda, bla, setb, edb, blb;
  wire  [1:0]       fa, fb;

  int n_tests = 0, n_fail = 0;
  int set_cnt = 0, n0, cnt, blink_at;
  logic set_prev = 1'b0, ed_after = 1'b1;
  logic [31:0] set_s = '0;

  typedef struct {
    logic [31:0] live;
    int          field;
    int          act;   // 0 none, 1 up, 2 down, 3 up+down
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[13];

  always #5 CLK = ~CLK;

  time_set_editor #(.DB_CYCLES(4), .TIMEOUT(100), .BLINK_HALF(10)) u_dut (
    .CLK(CLK), .RSTN(RSTN), .KEY_MODE_N(keys_n[0]), .KEY_UP_N(keys_n[1]),
    .KEY_DOWN_N(keys_n[2]), .KEY_CANCEL_N(keys_n[3]),
    .SEC0(live[0]), .SEC1(live[1]), .MIN0(live[2]), .MIN1(live[3]),
    .HOUR0(live[4]), .HOUR1(live[5]), .DAY0(live[6]), .DAY1(live[7]),
    .SSEC0(sa[0]), .SSEC1(sa[1]), .SMIN0(sa[2]), .SMIN1(sa[3]),
    .SHOUR0(sa[4]), .SHOUR1(sa[5]), .SDAY0(sa[6]), .SDAY1(sa[7]),
    .SET(seta), .EDITING(eda), .FIELD(fa), .BLINK(bla));

  time_set_editor #(.DB_CYCLES(4), .TIMEOUT(0), .BLINK_HALF(10)) u_dut0 (
    .CLK(CLK), .RSTN(RSTN), .KEY_MODE_N(keys_n[0]), .KEY_UP_N(keys_n[1]),
    .KEY_DOWN_N(keys_n[2]), .KEY_CANCEL_N(keys_n[3]),
    .SEC0(live[0]), .SEC1(live[1]), .MIN0(live[2]), .MIN1(live[3]),
    .HOUR0(live[4]), .HOUR1(live[5]), .DAY0(live[6]), .DAY1(live[7]),
    .SSEC0(sb[0]), .SSEC1(sb[1]), .SMIN0(sb[2]), .SMIN1(sb[3]),
    .SHOUR0(sb[4]), .SHOUR1(sb[5]), .SDAY0(sb[6]), .SDAY1(sb[7]),
    .SET(setb), .EDITING(edb), .FIELD(fb), .BLINK(blb));

  // SET watcher on the TIMEOUT=100 instance
  always @(negedge CLK) begin
    if (!RSTN) begin
      set_cnt  = 0;
      set_prev = 1'b0;
    end else begin
      if (set_prev) ed_after = eda;
      if (seta) begin
        set_cnt++;
        set_s = sa;
      end
      set_prev = seta;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    keys_n = 4'hF;
    repeat (3) @(negedge CLK);
    RSTN = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic press(input logic [3:0] m);
    keys_n = ~m;
    repeat (8) @(negedge CLK);
    keys_n = 4'hF;
    repeat (8) @(negedge CLK);
  endtask

  initial begin
    vecs[0]  = '{32'h31123456, 0, 1, 32'h01123456, "day31_up"};
    vecs[1]  = '{32'h01123456, 0, 2, 32'h31123456, "day01_dn"};
    vecs[2]  = '{32'h15230000, 1, 1, 32'h15000000, "hr23_up"};
    vecs[3]  = '{32'h15000000, 1, 2, 32'h15230000, "hr00_dn"};
    vecs[4]  = '{32'h15085930, 2, 1, 32'h15080030, "min59_up"};
    vecs[5]  = '{32'h15082000, 3, 2, 32'h15082059, "sec00_dn"};
    vecs[6]  = '{32'h15082009, 3, 1, 32'h15082010, "sec09_up"};
    vecs[7]  = '{32'h352742A3, 0, 0, 32'h01004200, "sanitise"};
    vecs[8]  = '{32'h15082000, 2, 3, 32'h15082000, "updn_ignored"};
    vecs[9]  = '{32'h09120000, 0, 1, 32'h10120000, "day09_up"};
    vecs[10] = '{32'h10120000, 0, 2, 32'h09120000, "day10_dn"};
    vecs[11] = '{32'h15190000, 1, 1, 32'h15200000, "hr19_up"};
    vecs[12] = '{32'h15085900, 2, 2, 32'h15085800, "min59_dn"};

    // reset state
    repeat (2) @(negedge CLK);
    chk("rst_s", sa, 32'h01000000);
    chk("rst_set", {31'd0, seta}, 32'd0);
    chk("rst_editing", {31'd0, eda}, 32'd0);
    chk("rst_field", {30'd0, fa}, 32'd0);
    chk("rst_blink", {31'd0, bla}, 32'd0);
    RSTN = 1'b1;
    repeat (2) @(negedge CLK);

    // entry latency and load
    live = 32'h15095958;
    keys_n = ~K_MODE;
    cnt = 0;
    while (!eda && cnt < 50) begin
      @(posedge CLK); #1;
      cnt++;
    end
    chk("mode_latency", cnt, 7);
    @(posedge CLK); #1;
    chk("load_s", sa, 32'h15095958);
    chk("load_field", {30'd0, fa}, 32'd0);
    @(negedge CLK);
    keys_n = 4'hF;
    repeat (8) @(negedge CLK);
    press(K_MODE);
    chk("main_field_hr", {30'd0, fa}, 32'd1);
    press(K_UP);
    chk("main_hr_up", sa, 32'h15105958);
    press(K_MODE); press(K_MODE); press(K_MODE);
    chk("commit_set_cnt", set_cnt, 1);
    chk("commit_s_at_set", set_s, 32'h15105958);
    chk("commit_ed_after", {31'd0, ed_after}, 32'd0);
    chk("commit_s_after", sa, 32'h15105958);

    // MODE+UP together: field advances, value untouched
    n0 = set_cnt;
    press(K_MODE);
    press(K_MODE | K_UP);
    chk("modeup_field", {30'd0, fa}, 32'd1);
    chk("modeup_s", sa, 32'h15095958);

    // 3-cycle glitch on UP must not register
    keys_n = ~K_UP;
    repeat (3) @(negedge CLK);
    keys_n = 4'hF;
    repeat (10) @(negedge CLK);
    chk("glitch_s", sa, 32'h15095958);

    // UP held 1000 cycles: one step only (no-timeout instance), other instance times out
    keys_n = ~K_UP;
    repeat (1000) @(negedge CLK);
    keys_n = 4'hF;
    repeat (10) @(negedge CLK);
    chk("hold_s", sb, 32'h15105958);
    chk("hold_editing", {31'd0, edb}, 32'd1);
    chk("hold_timeout_a", {31'd0, eda}, 32'd0);
    chk("hold_noset", set_cnt, n0);

    // cancel in E_MIN
    do_reset();
    live = 32'h15095958;
    press(K_MODE); press(K_MODE); press(K_MODE);
    chk("cancel_field_min", {30'd0, fa}, 32'd2);
    press(K_CAN);
    chk("cancel_editing", {31'd0, eda}, 32'd0);
    chk("cancel_field", {30'd0, fa}, 32'd0);
    chk("cancel_s", sa, 32'h15095958);
    chk("cancel_noset", set_cnt, 0);

    // timeout exactly 100 cycles after the last accepted pulse; blink phase from field entry
    do_reset();
    press(K_MODE);
    keys_n = ~K_MODE;
    cnt = 0;
    while (fa != 2'd1 && cnt < 50) begin
      @(posedge CLK); #1;
      cnt++;
    end
    chk("to_field_hr", {30'd0, fa}, 32'd1);
    cnt = 0;
    blink_at = 0;
    while (eda && cnt < 300) begin
      @(posedge CLK); #1;
      cnt++;
      if (cnt == 3) keys_n = 4'hF;
      if (bla && blink_at == 0) blink_at = cnt;
    end
    chk("timeout_cycles", cnt, 100);
    chk("blink_first_rise", blink_at, 10);
    @(negedge CLK);
    chk("timeout_noset", set_cnt, 0);
    chk("timeout_blink_off", {31'd0, bla}, 32'd0);

    // asynchronous reset in E_HOUR
    do_reset();
    live = 32'h22133344;
    press(K_MODE); press(K_MODE);
    chk("arst_pre_field", {30'd0, fa}, 32'd1);
    @(negedge CLK);
    #2 RSTN = 1'b0;
    #1;
    chk("arst_s", sa, 32'h01000000);
    chk("arst_editing", {31'd0, eda}, 32'd0);
    chk("arst_field", {30'd0, fa}, 32'd0);
    chk("arst_set", {31'd0, seta}, 32'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    repeat (2) @(negedge CLK);

    // vector table
    for (int i = 0; i < 13; i++) begin
      do_reset();
      live = vecs[i].live;
      press(K_MODE);
      for (int j = 0; j < vecs[i].field; j++) press(K_MODE);
      case (vecs[i].act)
        1: press(K_UP);
        2: press(K_DN);
        3: press(K_UP | K_DN);
        default: ;
      endcase
      chk({vecs[i].name, "_s"}, sa, vecs[i].exp);
      chk({vecs[i].name, "_field"}, {30'd0, fa}, vecs[i].field);
      chk({vecs[i].name, "_editing"}, {31'd0, eda}, 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
